// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter
// Contents: FSM state enum state_e (IDLE, ISSUE, WAIT, DONE), NUM_PORTS, BYTES_PER_WORD.
package mem_arb_pkg;
   localparam int NUM_PORTS = 2;
   localparam int BYTES_PER_WORD = 4;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: picks which pending request the arbiter serves next
// Ports: req0/req1 (in) pending requests, last_grant (in) id granted last time,
//        grant (out) id to serve (0 = fetch port, 1 = data port).
// Macro ARB_ROUND_ROBIN_EN: simultaneous requests alternate away from last_grant;
//        when undefined, port 0 has fixed priority and last_grant is ignored.
module mem_arb_grant (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant
);
`ifdef ARB_ROUND_ROBIN_EN
   assign grant = (req0 && req1) ? !last_grant : !req0;
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
   assign grant = !req0;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates two 32-bit word requesters onto a byte-wide shared memory
// Ports: clk, reset (sync, active high);
//        req0/req1, addr0/addr1, wdata0/wdata1, rwn0/rwn1 (in) requester side (1 = read);
//        ack0/ack1 (out) one-cycle completion pulse, rdata (out) read word valid with ack;
//        busy (out) high outside IDLE;
//        mem_start, mem_address, mem_data_in, mem_rwn (out), mem_data_out, mem_ready (in) memory side.
// Macro ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests (default: port 0 priority).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req0,
   input  logic                     req1,
   input  logic [ADDRESS_WIDTH-1:0] addr0,
   input  logic [ADDRESS_WIDTH-1:0] addr1,
   input  logic [31:0]              wdata0,
   input  logic [31:0]              wdata1,
   input  logic                     rwn0,
   input  logic                     rwn1,
   output logic                     ack0,
   output logic                     ack1,
   output logic [31:0]              rdata,
   output logic                     busy,
   output logic                     mem_start,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [31:0]              mem_data_in,
   output logic                     mem_rwn,
   input  logic [7:0]               mem_data_out,
   input  logic                     mem_ready
);
   state_e                   state_q, state_d;
   logic [1:0]               k_q, k_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]              wdata_q, wdata_d, rdata_q, rdata_d;
   logic                     rwn_q, rwn_d, gnt_q, gnt_d, last_grant_q, last_grant_d;
   logic                     first_q, first_d;
   logic                     gnt;

   mem_arb_grant u_grant (
      .req0       (req0),
      .req1       (req1),
      .last_grant (last_grant_q),
      .grant      (gnt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         k_q          <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         rwn_q        <= 1'b1;
         gnt_q        <= 1'b0;
         last_grant_q <= 1'b1;
         first_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         rwn_q        <= rwn_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         first_q      <= first_d;
      end
   end

   // first_q marks the WAIT cycle right after mem_start, when the memory may still show ready
   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      rwn_d        = rwn_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      first_d      = 1'b0;
      case (state_q)
         IDLE: if (req0 || req1) begin
            gnt_d        = gnt;
            last_grant_d = gnt;
            addr_d       = gnt ? addr1 : addr0;
            wdata_d      = gnt ? wdata1 : wdata0;
            rwn_d        = gnt ? rwn1 : rwn0;
            k_d          = '0;
            state_d      = ISSUE;
         end
         ISSUE: if (mem_ready) begin
            state_d = WAIT;
            first_d = 1'b1;
         end
         WAIT: if (!first_q && mem_ready) begin
            if (rwn_q) rdata_d[{k_q, 3'b000} +: 8] = mem_data_out;
            state_d = (k_q == 2'(BYTES_PER_WORD - 1)) ? DONE : ISSUE;
            k_d     = k_q + 2'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = state_q != IDLE;
   assign mem_start   = (state_q == ISSUE) && mem_ready;
   assign mem_address = addr_q + ADDRESS_WIDTH'(k_q);
   assign mem_data_in = {24'b0, wdata_q[{k_q, 3'b000} +: 8]};
   assign mem_rwn     = rwn_q;
   assign ack0        = (state_q == DONE) && !gnt_q;
   assign ack1        = (state_q == DONE) && gnt_q;
   assign rdata       = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector bench for mem_arbiter with a byte-memory model
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, rwn0 = 1'b1, rwn1 = 1'b1;
   logic [7:0]  addr0 = '0, addr1 = '0;
   logic [31:0] wdata0 = '0, wdata1 = '0;
   logic        ack0, ack1, busy, mem_start, mem_rwn;
   logic [31:0] rdata, mem_data_in;
   logic [7:0]  mem_address;
   logic [7:0]  mem_data_out = 8'h00;
   logic        mem_ready = 1'b1;

   logic [7:0]  mem [256];
   int          busy_cnt = 0;
   int          extra = 0;
   int          starts = 0;
   int          bad_starts = 0;
   int          checks = 0;
   int          errors = 0;

   mem_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .req0         (req0),
      .req1         (req1),
      .addr0        (addr0),
      .addr1        (addr1),
      .wdata0       (wdata0),
      .wdata1       (wdata1),
      .rwn0         (rwn0),
      .rwn1         (rwn1),
      .ack0         (ack0),
      .ack1         (ack1),
      .rdata        (rdata),
      .busy         (busy),
      .mem_start    (mem_start),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_rwn      (mem_rwn),
      .mem_data_out (mem_data_out),
      .mem_ready    (mem_ready)
   );

   always #5 clk = ~clk;

   // Memory drops ready for 1+extra cycles after each start, then returns data with ready.
   always @(posedge clk) begin
      if (mem_start) begin
         starts <= starts + 1;
         if (!mem_ready) bad_starts <= bad_starts + 1;
         if (!mem_rwn) mem[mem_address] <= mem_data_in[7:0];
         mem_data_out <= mem[mem_address];
         mem_ready    <= 1'b0;
         busy_cnt     <= extra;
      end else if (!mem_ready) begin
         if (busy_cnt == 0) mem_ready <= 1'b1;
         else busy_cnt <= busy_cnt - 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_txn(input logic port, input logic rwn, input logic [7:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic other);
      @(negedge clk);
      req0 = !port; req1 = port;
      addr0 = addr; addr1 = addr; wdata0 = wd; wdata1 = wd; rwn0 = rwn; rwn1 = rwn;
      lat = 0; other = 1'b0; rd = 'x;
      while (lat < 300) begin
         @(negedge clk);
         lat++;
         req0 = 1'b0; req1 = 1'b0;
         if (port ? ack0 : ack1) other = 1'b1;
         if (port ? ack1 : ack0) begin
            rd = rdata;
            break;
         end
      end
   endtask

   typedef struct {
      logic        port;
      logic        rwn;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int          lat, s0, cnt0, cnt1, n;
      logic [31:0] rd;
      logic        other;
      logic [7:0]  a;
      int          order[$];
      int          exp_order[4];
      vecs[0] = '{1'b1, 1'b0, 8'h10, 32'hDEADBEEF, 32'h00000000};
      vecs[1] = '{1'b0, 1'b1, 8'h10, 32'h00000000, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 1'b0, 8'hFE, 32'h11223344, 32'hDEADBEEF};
      vecs[3] = '{1'b1, 1'b1, 8'hFE, 32'h00000000, 32'h11223344};
      vecs[4] = '{1'b0, 1'b0, 8'h12, 32'hCAFEF00D, 32'h11223344};
      vecs[5] = '{1'b1, 1'b1, 8'h11, 32'h00000000, 32'hFEF00DBE};
      vecs[6] = '{1'b0, 1'b1, 8'h10, 32'h00000000, 32'hF00DBEEF};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_busy", {31'b0, busy}, 32'h0);
      check("reset_ack", {30'b0, ack1, ack0}, 32'h0);
      check("reset_mem_start", {31'b0, mem_start}, 32'h0);
      check("reset_rdata", rdata, 32'h0);

      for (int i = 0; i < 7; i++) begin
         s0 = starts;
         run_txn(vecs[i].port, vecs[i].rwn, vecs[i].addr, vecs[i].wdata, lat, rd, other);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'd13);
         check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
         check($sformatf("v%0d_other_ack", i), {31'b0, other}, 32'h0);
         check($sformatf("v%0d_starts", i), 32'(starts - s0), 32'd4);
         if (!vecs[i].rwn)
            for (int b = 0; b < 4; b++) begin
               a = vecs[i].addr + 8'(b);
               check($sformatf("v%0d_mem%0d", i, b), {24'b0, mem[a]}, {24'b0, vecs[i].wdata[8*b +: 8]});
            end
      end

      extra = 5;
      s0 = starts;
      run_txn(1'b0, 1'b1, 8'h10, 32'h0, lat, rd, other);
      check("slow_latency", 32'(lat), 32'd33);
      check("slow_rdata", rd, 32'hF00DBEEF);
      check("slow_starts", 32'(starts - s0), 32'd4);
      extra = 0;

      @(negedge clk);
      req0 = 1'b1; req1 = 1'b1;
      addr0 = 8'h10; addr1 = 8'hFE; rwn0 = 1'b1; rwn1 = 1'b1;
      cnt0 = 0; cnt1 = 0; n = 0;
      while (order.size() < 4 && n < 400) begin
         @(negedge clk);
         n++;
         if (ack0) begin
            order.push_back(0);
            check("arb_rdata0", rdata, 32'hF00DBEEF);
            cnt0++;
            if (cnt0 == 2) req0 = 1'b0;
         end
         if (ack1) begin
            order.push_back(1);
            check("arb_rdata1", rdata, 32'h11223344);
            cnt1++;
            if (cnt1 == 2) req1 = 1'b0;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{0, 0, 1, 1};
`endif
      check("arb_count", 32'(order.size()), 32'd4);
      for (int i = 0; i < 4 && i < order.size(); i++)
         check($sformatf("arb_order%0d", i), 32'(order[i]), 32'(exp_order[i]));

      extra = 4;
      @(negedge clk);
      req1 = 1'b1; addr1 = 8'h30; wdata1 = 32'h12345678; rwn1 = 1'b0;
      s0 = starts; n = 0; other = 1'b0;
      while (starts < s0 + 3 && n < 200) begin
         @(negedge clk);
         n++;
         req1 = 1'b0;
         if (ack0 || ack1) other = 1'b1;
      end
      check("abort_reached_byte2", 32'(starts - s0), 32'd3);
      reset = 1'b1;
      extra = 0;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", {31'b0, busy}, 32'h0);
      check("abort_no_ack", {30'b0, ack1 | other, ack0}, 32'h0);
      s0 = starts;
      run_txn(1'b0, 1'b1, 8'h10, 32'h0, lat, rd, other);
      check("after_abort_rdata", rd, 32'hF00DBEEF);
      check("after_abort_starts", 32'(starts - s0), 32'd4);
      check("after_abort_other_ack", {31'b0, other}, 32'h0);

      @(negedge clk);
      check("no_start_while_busy", 32'(bad_starts), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
